// File: rtl/pll_reset_seq.sv
// pll_reset_seq: reset/lock sequencer for the memory-clock rPLL.
// Pulses the PLL reset, waits for lock, requires the lock to stay stable,
// retries on timeout, and holds sys_rst until the PLL clock is usable.
// Optional feature macro: PLL_SEQ_LOCK_SYNC_EN (2-flop pll_lock synchronizer).
module pll_reset_seq #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 50000,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_reset,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state,
    output logic [3:0] retry_cnt,
    output logic [7:0] unlock_cnt
);

    localparam int unsigned MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_P  = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
    localparam int unsigned CW     = $clog2(MAX_P);

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LT_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] LS_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t        st;
    logic [CW-1:0] cnt;
    logic          lock_s;

`ifdef PLL_SEQ_LOCK_SYNC_EN
    logic [1:0] lock_sync;

    // Two-flop synchronizer bringing the asynchronous PLL lock into clkin
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) lock_sync <= '0;
        else       lock_sync <= {lock_sync[0], pll_lock};
    end

    assign lock_s = lock_sync[1];
`else
    assign lock_s = pll_lock;
`endif

    assign state = st;

    // Sequencer FSM; outputs are loaded on the same edge as the new state
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            st         <= S_RESET_PLL;
            cnt        <= '0;
            retry_cnt  <= '0;
            unlock_cnt <= '0;
            pll_reset  <= 1'b1;
            sys_rst    <= 1'b1;
            ready      <= 1'b0;
            fault      <= 1'b0;
        end else if (restart) begin
            st        <= S_RESET_PLL;
            cnt       <= '0;
            retry_cnt <= '0;
            pll_reset <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            case (st)
                S_RESET_PLL: begin
                    if (cnt == RST_LAST) begin
                        st        <= S_WAIT_LOCK;
                        cnt       <= '0;
                        pll_reset <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        st  <= S_STABLE;
                        cnt <= '0;
                    end else if (cnt == LT_LAST) begin
                        cnt       <= '0;
                        retry_cnt <= retry_cnt + 4'd1;
                        pll_reset <= 1'b1;
                        if (retry_cnt + 4'd1 == RETRY_MAX) begin
                            st    <= S_FAULT;
                            fault <= 1'b1;
                        end else begin
                            st <= S_RESET_PLL;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        st  <= S_WAIT_LOCK;
                        cnt <= '0;
                    end else if (cnt == LS_LAST) begin
                        st        <= S_RUN;
                        cnt       <= '0;
                        retry_cnt <= '0;
                        sys_rst   <= 1'b0;
                        ready     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        st        <= S_RESET_PLL;
                        cnt       <= '0;
                        pll_reset <= 1'b1;
                        sys_rst   <= 1'b1;
                        ready     <= 1'b0;
                        if (unlock_cnt != '1) unlock_cnt <= unlock_cnt + 8'd1;
                    end
                end
                S_FAULT: begin
                    cnt <= '0;
                end
                default: begin
                    st        <= S_RESET_PLL;
                    cnt       <= '0;
                    pll_reset <= 1'b1;
                    sys_rst   <= 1'b1;
                    ready     <= 1'b0;
                    fault     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed self-checking bench for pll_reset_seq (small timing parameters).
module tb_pll_reset_seq;

    localparam int RST = 4;
    localparam int LT  = 20;
    localparam int LS  = 8;
    localparam int MR  = 2;
`ifdef PLL_SEQ_LOCK_SYNC_EN
    localparam int SL  = 2;
`else
    localparam int SL  = 0;
`endif

    logic       clkin = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       restart;
    logic       pll_reset;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [2:0] state;
    logic [3:0] retry_cnt;
    logic [7:0] unlock_cnt;

    int checks = 0;
    int errors = 0;

    pll_reset_seq #(
        .RST_CYCLES  (RST),
        .LOCK_TIMEOUT(LT),
        .LOCK_STABLE (LS),
        .MAX_RETRY   (MR)
    ) dut (
        .clkin     (clkin),
        .reset     (reset),
        .pll_lock  (pll_lock),
        .restart   (restart),
        .pll_reset (pll_reset),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .fault     (fault),
        .state     (state),
        .retry_cnt (retry_cnt),
        .unlock_cnt(unlock_cnt)
    );

    always #5 clkin = ~clkin;

    // Advance n rising edges, then settle 1 time unit past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_pll_reset"}, 32'(pll_reset), 1);
        chk({tag, "_sys_rst"}, 32'(sys_rst), 1);
        chk({tag, "_ready"}, 32'(ready), 0);
        chk({tag, "_fault"}, 32'(fault), 0);
        chk({tag, "_retry"}, 32'(retry_cnt), 0);
        chk({tag, "_unlock"}, 32'(unlock_cnt), 0);
    endtask

    initial begin
        int w;
        reset    = 1'b1;
        pll_lock = 1'b0;
        restart  = 1'b0;
        #3;
        chk_reset_vals("por");

        // Nominal bring-up
        tick(2);
        reset = 1'b0;
        tick(RST - 1);
        chk("nom_pulse_hi", 32'(pll_reset), 1);
        chk("nom_pulse_state", 32'(state), 0);
        tick(1);
        chk("nom_pulse_lo", 32'(pll_reset), 0);
        chk("nom_wait_state", 32'(state), 1);
        tick(6);
        pll_lock = 1'b1;
        tick(1);                       // edge that first captures the lock rise
        tick(SL + LS - 1);
        chk("nom_ready_early", 32'(ready), 0);
        chk("nom_stable_state", 32'(state), 2);
        tick(1);
        chk("nom_ready", 32'(ready), 1);
        chk("nom_sys_rst", 32'(sys_rst), 0);
        chk("nom_run_state", 32'(state), 3);
        chk("nom_retry", 32'(retry_cnt), 0);

        // Lock loss in RUN
        pll_lock = 1'b0;
        tick(1 + SL - 1);
        chk("loss_ready_still", 32'(ready), 1);
        tick(1);
        chk("loss_ready", 32'(ready), 0);
        chk("loss_sys_rst", 32'(sys_rst), 1);
        chk("loss_unlock", 32'(unlock_cnt), 1);
        chk("loss_state", 32'(state), 0);
        chk("loss_pll_reset", 32'(pll_reset), 1);
        tick(RST - 1);
        chk("loss_pulse_hi", 32'(pll_reset), 1);
        tick(1);
        chk("loss_pulse_lo", 32'(pll_reset), 0);
        chk("loss_wait", 32'(state), 1);

        // Stability glitch inside STABLE
        pll_lock = 1'b1;
        tick(1 + SL);
        chk("gl_stable", 32'(state), 2);
        tick(5);
        pll_lock = 1'b0;
        tick(3);
        chk("gl_back_wait", 32'(state), 1);
        chk("gl_retry", 32'(retry_cnt), 0);
        chk("gl_ready", 32'(ready), 0);
        pll_lock = 1'b1;
        tick(1 + SL + LS - 1);
        chk("gl_ready_early", 32'(ready), 0);
        tick(1);
        chk("gl_ready", 32'(ready), 1);

        // Repeated lock loss: unlock_cnt saturates
        for (int k = 0; k < 300; k++) begin
            pll_lock = 1'b0;
            w = 0;
            while (state != 3'd0 && w < 20) begin tick(1); w++; end
            chk("sat_drop", 32'(state), 0);
            pll_lock = 1'b1;
            w = 0;
            while (ready !== 1'b1 && w < 40) begin tick(1); w++; end
            chk("sat_relock", 32'(ready), 1);
            if (k == 100) chk("sat_mid", 32'(unlock_cnt), 102);
        end
        chk("sat_unlock", 32'(unlock_cnt), 255);

        // Restart in RUN, then timeout/retry into FAULT
        restart  = 1'b1;
        pll_lock = 1'b0;
        tick(1);
        restart = 1'b0;
        chk("rr_state", 32'(state), 0);
        chk("rr_ready", 32'(ready), 0);
        chk("rr_pll_reset", 32'(pll_reset), 1);
        chk("rr_unlock_kept", 32'(unlock_cnt), 255);
        tick(RST - 1);
        chk("to_p1_hi", 32'(pll_reset), 1);
        tick(1);
        chk("to_p1_lo", 32'(pll_reset), 0);
        tick(LT - 1);
        chk("to_w1_state", 32'(state), 1);
        chk("to_w1_retry", 32'(retry_cnt), 0);
        tick(1);
        chk("to_r1_state", 32'(state), 0);
        chk("to_r1_retry", 32'(retry_cnt), 1);
        chk("to_r1_pll_reset", 32'(pll_reset), 1);
        tick(RST - 1);
        chk("to_p2_hi", 32'(pll_reset), 1);
        tick(1);
        chk("to_p2_lo", 32'(pll_reset), 0);
        tick(LT - 1);
        chk("to_w2_state", 32'(state), 1);
        tick(1);
        chk("to_fault_state", 32'(state), 4);
        chk("to_fault", 32'(fault), 1);
        chk("to_fault_retry", 32'(retry_cnt), 2);
        chk("to_fault_pll_reset", 32'(pll_reset), 1);
        tick(5);
        chk("to_fault_hold", 32'(state), 4);
        chk("to_fault_pll_hold", 32'(pll_reset), 1);
        chk("to_fault_sys_rst", 32'(sys_rst), 1);

        // Restart in FAULT
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        chk("rf_state", 32'(state), 0);
        chk("rf_fault", 32'(fault), 0);
        chk("rf_retry", 32'(retry_cnt), 0);

        // Restart colliding with the final WAIT_LOCK timeout
        tick(RST);
        chk("col_w1", 32'(state), 1);
        tick(LT);
        chk("col_r1_retry", 32'(retry_cnt), 1);
        tick(RST);
        chk("col_w2", 32'(state), 1);
        tick(LT - 1);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        chk("col_state", 32'(state), 0);
        chk("col_fault", 32'(fault), 0);
        chk("col_retry", 32'(retry_cnt), 0);
        tick(RST - 1);
        chk("col_pulse_hi", 32'(pll_reset), 1);
        tick(1);
        chk("col_pulse_lo", 32'(state), 1);

        // Asynchronous reset mid-STABLE
        pll_lock = 1'b1;
        tick(1 + SL + 3);
        chk("ar_stable", 32'(state), 2);
        #3;
        reset = 1'b1;
        #1;
        chk_reset_vals("ar");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
